// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the ALU issue sequencer.
//   - ALU operation codes driven on alu_control
//   - Branch condition codes
//   - Bit positions inside the stored {C,S,V,Z} flag register
//   - Sequencer FSM state encoding
package kgp_alu_pkg;

  // ALU operation codes
  localparam logic [2:0] AluAdd     = 3'b000;
  localparam logic [2:0] AluComp    = 3'b001;
  localparam logic [2:0] AluAnd     = 3'b010;
  localparam logic [2:0] AluXor     = 3'b011;
  localparam logic [2:0] AluSll     = 3'b100;
  localparam logic [2:0] AluSrl     = 3'b101;
  localparam logic [2:0] AluSra     = 3'b110;
  localparam logic [2:0] AluIllegal = 3'b111;

  // Branch condition codes
  localparam logic [2:0] CondAlways = 3'b000;
  localparam logic [2:0] CondZ      = 3'b001;
  localparam logic [2:0] CondNz     = 3'b010;
  localparam logic [2:0] CondC      = 3'b011;
  localparam logic [2:0] CondNc     = 3'b100;
  localparam logic [2:0] CondS      = 3'b101;
  localparam logic [2:0] CondNs     = 3'b110;
  localparam logic [2:0] CondV      = 3'b111;

  // Flag register bit indices
  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagS = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagZ = 0;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
//   cond  : 3-bit condition code
//   flags : stored {C,S,V,Z}
//   taken : condition is satisfied
module branch_cond_eval
  import kgp_alu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CondAlways: taken = 1'b1;
      CondZ:      taken = flags[FlagZ];
      CondNz:     taken = ~flags[FlagZ];
      CondC:      taken = flags[FlagC];
      CondNc:     taken = ~flags[FlagC];
      CondS:      taken = flags[FlagS];
      CondNs:     taken = ~flags[FlagS];
      CondV:      taken = flags[FlagV];
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer driving a combinational ALU.
// Accepts one operation per in_valid/in_ready handshake (IDLE), drives the ALU
// for exactly one cycle (EXEC), then holds a writeback packet until
// wb_valid/wb_ready (DONE).
//   in_*          : decoded operation from the decoder
//   alu_control,
//   operand0/1    : to the ALU (zero outside EXEC)
//   ALUResult,
//   *flag         : from the ALU, sampled only at the end of EXEC
//   wb_*          : writeback packet with back-pressure
//   branch_taken  : branch resolution, valid while wb_valid
//   flags         : stored {C,S,V,Z}
//   illegal_op    : one-cycle pulse after EXEC of aluop 3'b111
module alu_issue_ctrl
  import kgp_alu_pkg::*;
#(
  parameter int unsigned size     = 32,
  parameter int unsigned aluCSize = 3,
  parameter int unsigned regAddr  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [aluCSize-1:0] in_aluop,
  input  logic [size-1:0]     in_op0,
  input  logic [size-1:0]     in_op1,
  input  logic [regAddr-1:0]  in_rd,
  input  logic                in_wr_en,
  input  logic                in_flag_upd,
  input  logic                in_is_branch,
  input  logic [2:0]          in_cond,
  output logic [aluCSize-1:0] alu_control,
  output logic [size-1:0]     operand0,
  output logic [size-1:0]     operand1,
  input  logic [size-1:0]     ALUResult,
  input  logic                carryflag,
  input  logic                signflag,
  input  logic                overflowflag,
  input  logic                zflag,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [regAddr-1:0]  wb_rd,
  output logic [size-1:0]     wb_data,
  output logic                wb_wr_en,
  output logic                branch_taken,
  output logic [3:0]          flags,
  output logic                illegal_op
);

  state_e state_q, state_d;

  // Latched operation
  logic [aluCSize-1:0] op_q;
  logic [size-1:0]     op0_q, op1_q;
  logic [regAddr-1:0]  rd_q;
  logic                wr_en_q, flag_upd_q, is_branch_q;
  logic [2:0]          cond_q;

  // Writeback packet and architectural flags
  logic [size-1:0]     wb_data_q;
  logic [regAddr-1:0]  wb_rd_q;
  logic                wb_wr_en_q, branch_taken_q, illegal_q;
  logic [3:0]          flags_q;

  logic accept, in_exec, is_shift, is_illegal, cond_taken;

  assign accept  = in_valid & in_ready;
  assign in_exec = (state_q == StExec);

  always_comb begin
    is_shift   = 1'b0;
    is_illegal = 1'b0;
    case (op_q)
      aluCSize'(AluSll), aluCSize'(AluSrl), aluCSize'(AluSra): is_shift = 1'b1;
      aluCSize'(AluIllegal):                                   is_illegal = 1'b1;
      default: ;
    endcase
  end

  // Evaluated against the flags held before this operation's own update.
  branch_cond_eval u_branch_cond_eval (
    .cond  (cond_q),
    .flags (flags_q),
    .taken (cond_taken)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  if (wb_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == StIdle);
    wb_valid    = (state_q == StDone);
    alu_control = '0;
    operand0    = '0;
    operand1    = '0;
    if (in_exec) begin
      alu_control = op_q;
      operand0    = op0_q;
      // Shifts only see a 5-bit shift amount.
      operand1    = is_shift ? {{(size-5){1'b0}}, op1_q[4:0]} : op1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      op_q           <= '0;
      op0_q          <= '0;
      op1_q          <= '0;
      rd_q           <= '0;
      wr_en_q        <= 1'b0;
      flag_upd_q     <= 1'b0;
      is_branch_q    <= 1'b0;
      cond_q         <= '0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_wr_en_q     <= 1'b0;
      branch_taken_q <= 1'b0;
      flags_q        <= 4'b0000;
      illegal_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= in_exec & is_illegal;
      if (accept) begin
        op_q        <= in_aluop;
        op0_q       <= in_op0;
        op1_q       <= in_op1;
        rd_q        <= in_rd;
        wr_en_q     <= in_wr_en;
        flag_upd_q  <= in_flag_upd;
        is_branch_q <= in_is_branch;
        cond_q      <= in_cond;
      end
      if (in_exec) begin
        wb_data_q      <= is_illegal ? '0 : ALUResult;
        wb_rd_q        <= rd_q;
        wb_wr_en_q     <= wr_en_q & ~is_illegal;
        branch_taken_q <= is_branch_q & cond_taken;
        if (flag_upd_q && !is_illegal) begin
          flags_q <= {carryflag, signflag, overflowflag, zflag};
        end
      end
    end
  end

  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_wr_en     = wb_wr_en_q;
  assign branch_taken = branch_taken_q;
  assign flags        = flags_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, reset
// mid-operation sequence, and randomized operations against a reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_aluop;
  logic [31:0] in_op0, in_op1;
  logic [4:0]  in_rd;
  logic        in_wr_en, in_flag_upd, in_is_branch;
  logic [2:0]  in_cond;
  logic [2:0]  alu_control;
  logic [31:0] operand0, operand1, ALUResult;
  logic        carryflag, signflag, overflowflag, zflag;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_wr_en, branch_taken;
  logic [3:0]  flags;
  logic        illegal_op;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluop     (in_aluop),
    .in_op0       (in_op0),
    .in_op1       (in_op1),
    .in_rd        (in_rd),
    .in_wr_en     (in_wr_en),
    .in_flag_upd  (in_flag_upd),
    .in_is_branch (in_is_branch),
    .in_cond      (in_cond),
    .alu_control  (alu_control),
    .operand0     (operand0),
    .operand1     (operand1),
    .ALUResult    (ALUResult),
    .carryflag    (carryflag),
    .signflag     (signflag),
    .overflowflag (overflowflag),
    .zflag        (zflag),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_wr_en     (wb_wr_en),
    .branch_taken (branch_taken),
    .flags        (flags),
    .illegal_op   (illegal_op)
  );

  // Behavioural ALU: returns {C,S,V,Z,result}. Illegal op yields junk so that
  // any leak into wb_data or flags is visible.
  function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a << b;
      3'd5: r = a >> b;
      3'd6: r = 32'($signed(a) >>> b);
      default: begin
        r = 32'hDEADBEEF;
        c = 1'b1;
        v = 1'b1;
      end
    endcase
    return {c, r[31], v, (r == 32'd0), r};
  endfunction

  logic [35:0] alu_out;
  always_comb alu_out = alu_fn(alu_control, operand0, operand1);
  assign ALUResult    = alu_out[31:0];
  assign carryflag    = alu_out[35];
  assign signflag     = alu_out[34];
  assign overflowflag = alu_out[33];
  assign zflag        = alu_out[32];

  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
    case (cond)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[3];
      3'd4: return !f[3];
      3'd5: return f[2];
      3'd6: return !f[2];
      default: return f[1];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full transaction and checks every observable phase.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wr, input logic fu, input logic br,
                       input logic [2:0] cond, input int unsigned hold,
                       input logic [31:0] exp_data, input logic [3:0] exp_flags,
                       input logic exp_taken);
    logic [31:0] exp_op1;
    logic        exp_ill;
    int          n;
    exp_ill = (op == 3'b111);
    exp_op1 = (op >= 3'd4 && op <= 3'd6) ? (b & 32'h1F) : b;
    n = 0;
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; in_aluop = op; in_op0 = a; in_op1 = b; in_rd = rd;
    in_wr_en = wr; in_flag_upd = fu; in_is_branch = br; in_cond = cond;
    step();
    in_valid = 1'b0;
    // EXEC
    check("exec_in_ready", 32'(in_ready), 32'd0);
    check("exec_wb_valid", 32'(wb_valid), 32'd0);
    check("exec_alu_control", 32'(alu_control), 32'(op));
    check("exec_operand0", operand0, a);
    check("exec_operand1", operand1, exp_op1);
    step();
    // DONE, first cycle (T+2)
    check("done_wb_valid", 32'(wb_valid), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("wb_data", wb_data, exp_data);
    check("wb_rd", 32'(wb_rd), 32'(rd));
    check("wb_wr_en", 32'(wb_wr_en), 32'(wr & ~exp_ill));
    check("branch_taken", 32'(branch_taken), 32'(exp_taken));
    check("flags", 32'(flags), 32'(exp_flags));
    check("illegal_op", 32'(illegal_op), 32'(exp_ill));
    for (int h = 0; h < int'(hold); h++) begin
      step();
      check("hold_wb_valid", 32'(wb_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_wb_data", wb_data, exp_data);
      check("hold_wb_rd", 32'(wb_rd), 32'(rd));
      check("hold_branch_taken", 32'(branch_taken), 32'(exp_taken));
      check("hold_illegal_op", 32'(illegal_op), 32'd0);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_wb_valid", 32'(wb_valid), 32'd0);
    check("post_illegal_op", 32'(illegal_op), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr;
    logic        fu;
    logic        br;
    logic [2:0]  cond;
    int unsigned hold;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
    logic        exp_taken;
  } vec_t;

  localparam int NumVec = 18;
  vec_t tbl[NumVec];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  mflags;
    logic [2:0]  op, cond;
    logic [31:0] a, b, bm, exp_data;
    logic [35:0] res;
    logic        ill, br, fu, taken;

    //          op      a             b             rd    wr    fu    br    cond  hold data          flags    taken
    tbl[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 5'd1, 1'b1, 1'b1, 1'b0, 3'd0, 0, 32'h80000000, 4'b0110, 1'b0};
    tbl[1]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 5'd2, 1'b1, 1'b1, 1'b0, 3'd0, 0, 32'h00000000, 4'b1001, 1'b0};
    tbl[2]  = '{3'd0, 32'h00000010, 32'h00000004, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 0, 32'h00000014, 4'b1001, 1'b1};
    tbl[3]  = '{3'd0, 32'h00000010, 32'h00000004, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 0, 32'h00000014, 4'b1001, 1'b0};
    tbl[4]  = '{3'd0, 32'h00000010, 32'h00000004, 5'd0, 1'b0, 1'b0, 1'b1, 3'd3, 0, 32'h00000014, 4'b1001, 1'b1};
    tbl[5]  = '{3'd0, 32'h00000010, 32'h00000004, 5'd0, 1'b0, 1'b0, 1'b1, 3'd4, 0, 32'h00000014, 4'b1001, 1'b0};
    tbl[6]  = '{3'd4, 32'h00000001, 32'h00000021, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0, 0, 32'h00000002, 4'b1001, 1'b0};
    tbl[7]  = '{3'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd4, 1'b1, 1'b1, 1'b0, 3'd0, 3, 32'hFF00FF00, 4'b0100, 1'b0};
    tbl[8]  = '{3'd7, 32'h12345678, 32'h00000001, 5'd5, 1'b1, 1'b1, 1'b0, 3'd0, 1, 32'h00000000, 4'b0100, 1'b0};
    tbl[9]  = '{3'd0, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1, 3'd5, 0, 32'h00000000, 4'b0100, 1'b1};
    tbl[10] = '{3'd0, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1, 3'd7, 0, 32'h00000000, 4'b0100, 1'b0};
    tbl[11] = '{3'd6, 32'h80000000, 32'h00000024, 5'd6, 1'b1, 1'b1, 1'b0, 3'd0, 0, 32'hF8000000, 4'b0100, 1'b0};
    tbl[12] = '{3'd5, 32'h80000000, 32'h0000001F, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0, 0, 32'h00000001, 4'b0100, 1'b0};
    tbl[13] = '{3'd1, 32'h00000005, 32'h00000005, 5'd8, 1'b1, 1'b1, 1'b0, 3'd0, 0, 32'h00000000, 4'b0001, 1'b0};
    tbl[14] = '{3'd2, 32'h0000F0F0, 32'h00000F0F, 5'd9, 1'b1, 1'b1, 1'b0, 3'd0, 2, 32'h00000000, 4'b0001, 1'b0};
    tbl[15] = '{3'd0, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0, 0, 32'h00000000, 4'b0001, 1'b1};
    tbl[16] = '{3'd1, 32'h00000003, 32'h00000005, 5'd10, 1'b1, 1'b1, 1'b0, 3'd0, 0, 32'hFFFFFFFE, 4'b1100, 1'b0};
    tbl[17] = '{3'd0, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1, 3'd6, 0, 32'h00000000, 4'b1100, 1'b0};

    in_valid = 1'b0; in_aluop = '0; in_op0 = '0; in_op1 = '0; in_rd = '0;
    in_wr_en = 1'b0; in_flag_upd = 1'b0; in_is_branch = 1'b0; in_cond = '0;
    wb_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_wr_en", 32'(wb_wr_en), 32'd0);
    check("rst_branch_taken", 32'(branch_taken), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_illegal_op", 32'(illegal_op), 32'd0);
    check("rst_alu_control", 32'(alu_control), 32'd0);
    check("rst_operand0", operand0, 32'd0);
    check("rst_operand1", operand1, 32'd0);

    for (int i = 0; i < NumVec; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].wr, tbl[i].fu, tbl[i].br,
            tbl[i].cond, tbl[i].hold, tbl[i].exp_data, tbl[i].exp_flags, tbl[i].exp_taken);
    end

    // Reset asserted during EXEC of an XOR drops the transaction and clears flags.
    in_valid = 1'b1; in_aluop = 3'd3; in_op0 = 32'h0000FFFF; in_op1 = 32'h12345678;
    in_rd = 5'd11; in_wr_en = 1'b1; in_flag_upd = 1'b1; in_is_branch = 1'b0; in_cond = '0;
    step();
    in_valid = 1'b0;
    check("rstx_exec_alu_control", 32'(alu_control), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstx_wb_valid", 32'(wb_valid), 32'd0);
    check("rstx_flags", 32'(flags), 32'd0);
    check("rstx_in_ready", 32'(in_ready), 32'd1);
    check("rstx_operand0", operand0, 32'd0);
    step();
    check("rstx_still_idle", 32'(wb_valid), 32'd0);
    do_op(3'd0, 32'd2, 32'd3, 5'd12, 1'b1, 1'b1, 1'b0, 3'd0, 0, 32'd5, 4'b0000, 1'b0);

    // Randomized operations against the reference model.
    mflags = 4'b0000;
    for (int i = 0; i < 250; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      br   = ($urandom_range(0, 2) == 0);
      fu   = br ? 1'b0 : 1'($urandom_range(0, 1));
      cond = 3'($urandom_range(0, 7));
      bm   = (op >= 3'd4 && op <= 3'd6) ? {27'd0, b[4:0]} : b;
      res  = alu_fn(op, a, bm);
      ill  = (op == 3'd7);
      exp_data = ill ? 32'd0 : res[31:0];
      taken = br && cond_met(cond, mflags);
      if (fu && !ill) mflags = res[35:32];
      do_op(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), fu, br, cond,
            $urandom_range(0, 2), exp_data, mflags, taken);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
